// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and helpers for the Wishbone round-robin arbiter family.
//   state_t    : arbiter FSM states (IDLE, GRANT, RELEASE)
//   idx_t      : master index, wide enough for up to MAX_MASTERS plus NO_MASTER
//   NO_MASTER  : all-ones index meaning "nobody selected"
//   rr_pick()  : round-robin search starting at last+1, wrapping modulo n
// -----------------------------------------------------------------------------
package wb_arb_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int IDX_W       = 4;

  typedef logic [IDX_W-1:0] idx_t;

  // One bit wider than a master index, so it can never alias master 7.
  localparam idx_t NO_MASTER = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Returns the first requester found at last+1, last+2, ... (mod n), or
  // NO_MASTER when req is empty. The loop walks the offsets downwards so that
  // the smallest offset (highest priority) is the final assignment.
  function automatic idx_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                   input int                     n,
                                   input idx_t                   last);
    idx_t pick;
    int   cand;
    pick = NO_MASTER;
    for (int off = n; off >= 1; off--) begin
      cand = (int'(last) + off) % n;
      if (req[cand]) pick = idx_t'(cand);
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_rr_prio_enc.sv
// -----------------------------------------------------------------------------
// wb_rr_prio_enc
// Round-robin priority encoder: given a request vector and the index that was
// served last, returns the index of the next master to serve.
//   req   in  N      request vector (one bit per master)
//   last  in  idx_t  index served most recently
//   next  out idx_t  next index to grant (NO_MASTER when req is empty)
//   valid out 1      at least one request present
// -----------------------------------------------------------------------------
module wb_rr_prio_enc
  import wb_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  idx_t         last,
  output idx_t         next,
  output logic         valid
);

  logic [MAX_MASTERS-1:0] req_ext;

  assign req_ext = MAX_MASTERS'(req);
  assign next    = rr_pick(req_ext, N, last);
  assign valid   = |req;

endmodule

// File: rtl/wb_rr_arbiter_nx1.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter_nx1
// Round-robin Wishbone arbiter sharing one slave port between N_MASTERS
// masters. The grant is held for the whole of the owner's CYC, and one dead
// cycle (RELEASE) separates consecutive owners so slave CYC always drops.
//
// Optional build macro: WB_ARB_TIMEOUT_EN
//   Adds a stall watchdog (TIMEOUT_CYCLES) that answers a hung transfer with
//   ERR, and a sticky timeout_flag output.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   m_adr/m_dat_w/m_sel/m_cti/m_bte   flattened master request fields (slice i = master i)
//   m_cyc/m_stb/m_we          per-master CYC/STB/WE
//   m_dat_r                   read data broadcast to all masters
//   m_ack/m_err               per-master response (only the owner ever sees one)
//   s_*                       slave request (zero when nobody owns the bus)
//   s_dat_r/s_ack/s_err       slave response
//   timeout_flag              sticky watchdog indication (WB_ARB_TIMEOUT_EN only)
//   gnt                       one-hot current owner
// -----------------------------------------------------------------------------
module wb_rr_arbiter_nx1
  import wb_arb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int N_MASTERS      = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]   m_adr,
  input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]   m_dat_w,
  input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0] m_sel,
  input  logic [N_MASTERS*3-1:0]               m_cti,
  input  logic [N_MASTERS*2-1:0]               m_bte,
  input  logic [N_MASTERS-1:0]                 m_cyc,
  input  logic [N_MASTERS-1:0]                 m_stb,
  input  logic [N_MASTERS-1:0]                 m_we,
  output logic [WB_DATA_WIDTH-1:0]             m_dat_r,
  output logic [N_MASTERS-1:0]                 m_ack,
  output logic [N_MASTERS-1:0]                 m_err,
  output logic [WB_ADDR_WIDTH-1:0]             s_adr,
  output logic [WB_DATA_WIDTH-1:0]             s_dat_w,
  output logic [WB_DATA_WIDTH/8-1:0]           s_sel,
  output logic [2:0]                           s_cti,
  output logic [1:0]                           s_bte,
  output logic                                 s_cyc,
  output logic                                 s_stb,
  output logic                                 s_we,
  input  logic [WB_DATA_WIDTH-1:0]             s_dat_r,
  input  logic                                 s_ack,
  input  logic                                 s_err,
`ifdef WB_ARB_TIMEOUT_EN
  output logic                                 timeout_flag,
`endif
  output logic [N_MASTERS-1:0]                 gnt
);

  localparam int SW = WB_DATA_WIDTH / 8;

  state_t state_q, state_d;
  idx_t   idx_q;     // current owner
  idx_t   last_q;    // round-robin pointer: most recently granted master
  idx_t   next_idx;
  logic   req_valid;
  logic   grant_take;
  logic   timeout_hit;

  // Selected master's request, independent of state; gated in the output logic.
  logic [N_MASTERS-1:0]     gnt_vec;
  logic [WB_ADDR_WIDTH-1:0] sel_adr;
  logic [WB_DATA_WIDTH-1:0] sel_dat_w;
  logic [SW-1:0]            sel_sel;
  logic [2:0]               sel_cti;
  logic [1:0]               sel_bte;
  logic                     sel_cyc, sel_stb, sel_we;

  wb_rr_prio_enc #(.N(N_MASTERS)) u_prio_enc (
    .req   (m_cyc),
    .last  (last_q),
    .next  (next_idx),
    .valid (req_valid)
  );

  assign grant_take = (state_q == IDLE) && req_valid;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = GRANT;
      GRANT:   if (!sel_cyc || timeout_hit) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner index and round-robin pointer, both captured when a grant is taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q  <= NO_MASTER;
      last_q <= idx_t'(N_MASTERS - 1);
    end else if (grant_take) begin
      idx_q  <= next_idx;
      last_q <= next_idx;
    end
  end

  // Slice mux for the owning master.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can infer a latch.
    gnt_vec   = '0;
    sel_adr   = '0;
    sel_dat_w = '0;
    sel_sel   = '0;
    sel_cti   = '0;
    sel_bte   = '0;
    sel_cyc   = 1'b0;
    sel_stb   = 1'b0;
    sel_we    = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (idx_q == idx_t'(i)) begin
        gnt_vec[i] = 1'b1;
        sel_adr    = m_adr[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
        sel_dat_w  = m_dat_w[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
        sel_sel    = m_sel[i*SW +: SW];
        sel_cti    = m_cti[i*3 +: 3];
        sel_bte    = m_bte[i*2 +: 2];
        sel_cyc    = m_cyc[i];
        sel_stb    = m_stb[i];
        sel_we     = m_we[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional stall watchdog
  // ---------------------------------------------------------------------------
`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          stall;

  // A stalled cycle is a strobed GRANT cycle with no slave response; the
  // watchdog fires during the TIMEOUT_CYCLES-th such cycle.
  assign stall       = (state_q == GRANT) && sel_cyc && sel_stb && !s_ack && !s_err;
  assign timeout_hit = stall && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q        <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (grant_take || ((state_q == GRANT) && (s_ack || s_err))) begin
        cnt_q <= '0;
      end else if (stall) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (timeout_hit) timeout_flag <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    m_dat_r = s_dat_r;
    m_ack   = '0;
    m_err   = '0;
    gnt     = '0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_cti   = '0;
    s_bte   = '0;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    if (state_q == GRANT) begin
      gnt     = gnt_vec;
      s_adr   = sel_adr;
      s_dat_w = sel_dat_w;
      s_sel   = sel_sel;
      s_cti   = sel_cti;
      s_bte   = sel_bte;
      s_we    = sel_we;
      // A watchdog hit drops the slave request in the same cycle as the ERR.
      s_cyc   = sel_cyc && !timeout_hit;
      s_stb   = sel_stb && sel_cyc && !timeout_hit;
      m_ack   = gnt_vec & {N_MASTERS{s_ack}};
      m_err   = gnt_vec & {N_MASTERS{s_err || timeout_hit}};
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter_nx1.sv
// -----------------------------------------------------------------------------
// tb_wb_rr_arbiter_nx1
// Self-checking bench for wb_rr_arbiter_nx1 (N_MASTERS=3, 32-bit bus).
// Master requests push their expected beats to a scoreboard in the order the
// round-robin arbiter must serve them; each response popped from the queue is
// compared against the slave-side request and the per-master response vectors.
// The slave model answers combinationally; read data is ~address.
// With WB_ARB_TIMEOUT_EN defined, a watchdog scenario is run as well.
// -----------------------------------------------------------------------------
module tb_wb_rr_arbiter_nx1;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat_w;
  logic [N*SW-1:0] m_sel;
  logic [N*3-1:0]  m_cti;
  logic [N*2-1:0]  m_bte;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [DW-1:0]   m_dat_r;
  logic [N-1:0]    m_ack, m_err;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_w;
  logic [SW-1:0]   s_sel;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;
  logic            s_cyc, s_stb, s_we;
  logic [DW-1:0]   s_dat_r;
  logic            s_ack, s_err;
  logic [N-1:0]    gnt;
`ifdef WB_ARB_TIMEOUT_EN
  logic            timeout_flag;
`endif

  logic ack_mode, err_mode;

  assign s_ack   = ack_mode & s_cyc & s_stb;
  assign s_err   = err_mode & s_cyc & s_stb;
  assign s_dat_r = ~s_adr;

  always #5 clk = ~clk;

  wb_rr_arbiter_nx1 #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .N_MASTERS     (N),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .m_adr   (m_adr),
    .m_dat_w (m_dat_w),
    .m_sel   (m_sel),
    .m_cti   (m_cti),
    .m_bte   (m_bte),
    .m_cyc   (m_cyc),
    .m_stb   (m_stb),
    .m_we    (m_we),
    .m_dat_r (m_dat_r),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .s_adr   (s_adr),
    .s_dat_w (s_dat_w),
    .s_sel   (s_sel),
    .s_cti   (s_cti),
    .s_bte   (s_bte),
    .s_cyc   (s_cyc),
    .s_stb   (s_stb),
    .s_we    (s_we),
    .s_dat_r (s_dat_r),
    .s_ack   (s_ack),
    .s_err   (s_err),
`ifdef WB_ARB_TIMEOUT_EN
    .timeout_flag(timeout_flag),
`endif
    .gnt     (gnt)
  );

  typedef struct {
    int          id;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   beats_left[N];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_id  = -1;
  bit   gap_seen = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic clear_masters();
    m_adr   = '0;
    m_dat_w = '0;
    m_sel   = '0;
    m_cti   = '0;
    m_bte   = '0;
    m_cyc   = '0;
    m_stb   = '0;
    m_we    = '0;
    for (int i = 0; i < N; i++) beats_left[i] = 0;
  endtask

  // Raise a request on master i and queue the beats it expects to complete.
  task automatic start(input int i, input logic [31:0] adr, input logic [31:0] dat,
                       input logic we, input int beats);
    exp_t e;
    m_adr[i*AW +: AW]   = adr;
    m_dat_w[i*DW +: DW] = dat;
    m_we[i]             = we;
    m_sel[i*SW +: SW]   = '1;
    m_cti[i*3 +: 3]     = (beats > 1) ? 3'b010 : 3'b111;
    m_bte[i*2 +: 2]     = 2'b00;
    m_cyc[i]            = 1'b1;
    m_stb[i]            = 1'b1;
    beats_left[i]       = beats;
    for (int k = 0; k < beats; k++) begin
      e.id  = i;
      e.adr = adr + 32'(4 * k);
      e.we  = we;
      e.dat = we ? (dat + 32'(k)) : ~(adr + 32'(4 * k));
      e.err = err_mode;
      sb.push_back(e);
    end
  endtask

  // Master-side reaction to a completed beat (called just after the edge).
  task automatic advance(input int i);
    beats_left[i]--;
    if (beats_left[i] == 0) begin
      m_cyc[i]        = 1'b0;
      m_stb[i]        = 1'b0;
      m_cti[i*3 +: 3] = 3'b000;
    end else begin
      m_adr[i*AW +: AW]   = m_adr[i*AW +: AW] + 32'd4;
      m_dat_w[i*DW +: DW] = m_dat_w[i*DW +: DW] + 32'd1;
      if (beats_left[i] == 1) m_cti[i*3 +: 3] = 3'b111;
    end
  endtask

  // Watch responses on the falling edge and compare each against the scoreboard.
  task automatic run(input int max_acks, input int budget);
    int   acks   = 0;
    int   cycles = 0;
    exp_t e;
    while (acks < max_acks && sb.size() > 0) begin
      @(negedge clk);
      cycles++;
      if (cycles > budget) begin
        check("run_budget_left", 64'(sb.size()), 64'd0);
        break;
      end
      if (|(m_ack | m_err)) begin
        e = sb.pop_front();
        check("s_cyc", s_cyc, 1'b1);
        check("gnt", gnt, onehot(e.id));
        check("ack_vec", m_ack, e.err ? '0 : onehot(e.id));
        check("err_vec", m_err, e.err ? onehot(e.id) : '0);
        check("s_adr", s_adr, e.adr);
        check("s_we", s_we, e.we);
        check("s_sel", s_sel, 4'hF);
        if (e.we) check("s_dat_w", s_dat_w, e.dat);
        else if (!e.err) check("m_dat_r", m_dat_r, e.dat);
        if (e.id != last_id) check("owner_gap", gap_seen, 1'b1);
        last_id  = e.id;
        gap_seen = 1'b0;
        acks++;
        @(posedge clk);
        #1;
        advance(e.id);
      end else if (gnt == '0 && !s_cyc) begin
        gap_seen = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    clear_masters();
    sb.delete();
    #2;
    check("rst_gnt", gnt, '0);
    check("rst_s_cyc", s_cyc, 1'b0);
    check("rst_s_stb", s_stb, 1'b0);
    check("rst_s_we", s_we, 1'b0);
    check("rst_s_adr", s_adr, '0);
    check("rst_m_ack", m_ack, '0);
    check("rst_m_err", m_err, '0);
`ifdef WB_ARB_TIMEOUT_EN
    check("rst_timeout_flag", timeout_flag, 1'b0);
`endif
    @(negedge clk);
    rstn     = 1'b1;
    last_id  = -1;
    gap_seen = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    ack_mode = 1'b1;
    err_mode = 1'b0;
    clear_masters();

    // 1: single write from master 1, one-cycle arbitration latency.
    do_reset();
    start(1, 32'h100, 32'hDEADBEEF, 1'b1, 1);
    @(negedge clk);
    check("t1_latency_s_cyc", s_cyc, 1'b0);
    check("t1_latency_gnt", gnt, '0);
    run(1, 20);
    idle(3);

    // 2: three simultaneous requests, two rounds, order 0,1,2 each time.
    do_reset();
    start(0, 32'h010, 32'h11110000, 1'b1, 1);
    start(1, 32'h020, 32'h0, 1'b0, 1);
    start(2, 32'h030, 32'h22220000, 1'b1, 1);
    run(3, 40);
    idle(3);
    start(0, 32'h040, 32'h0, 1'b0, 1);
    start(1, 32'h050, 32'h33330000, 1'b1, 1);
    start(2, 32'h060, 32'h0, 1'b0, 1);
    run(3, 40);
    idle(3);

    // 3: master 0 4-beat burst holds the bus while master 2 waits.
    do_reset();
    start(0, 32'h200, 32'hA0000000, 1'b1, 4);
    start(2, 32'h300, 32'h0, 1'b0, 1);
    run(5, 60);
    idle(3);

    // 4: slave error on master 2's read.
    ack_mode = 1'b0;
    err_mode = 1'b1;
    start(2, 32'h500, 32'h0, 1'b0, 1);
    run(1, 20);
    ack_mode = 1'b1;
    err_mode = 1'b0;
    idle(3);

    // 5: asynchronous reset mid-burst, then the pointer restarts at master 0.
    do_reset();
    start(0, 32'h600, 32'hB0000000, 1'b1, 4);
    start(1, 32'h700, 32'hC0000000, 1'b1, 1);
    run(2, 30);
    #2;
    check("t5_pre_s_cyc", s_cyc, 1'b1);
    check("t5_pre_ack", m_ack, 3'b001);
    rstn = 1'b0;
    #1;
    check("t5_async_s_cyc", s_cyc, 1'b0);
    check("t5_async_s_stb", s_stb, 1'b0);
    check("t5_async_gnt", gnt, '0);
    check("t5_async_m_ack", m_ack, '0);
    clear_masters();
    sb.delete();
    @(negedge clk);
    rstn     = 1'b1;
    last_id  = -1;
    gap_seen = 1'b1;
    @(posedge clk);
    #1;
    start(0, 32'h800, 32'h0, 1'b0, 1);
    start(1, 32'h900, 32'hD0000000, 1'b1, 1);
    start(2, 32'hA00, 32'h0, 1'b0, 1);
    run(3, 40);
    idle(3);

`ifdef WB_ARB_TIMEOUT_EN
    // 6: slave never answers; ERR must pulse on the 8th stalled cycle.
    begin
      int stalled;
      bit seen;
      do_reset();
      ack_mode = 1'b0;
      err_mode = 1'b0;
      stalled  = 0;
      seen     = 1'b0;
      start(1, 32'hB00, 32'h12345678, 1'b1, 1);
      sb.delete();
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clk);
        if (m_err[1]) begin
          seen = 1'b1;
          check("t6_err_vec", m_err, 3'b010);
          check("t6_err_s_cyc", s_cyc, 1'b0);
          check("t6_err_s_stb", s_stb, 1'b0);
        end else if (s_stb) begin
          stalled++;
        end
      end
      check("t6_timeout_seen", seen, 1'b1);
      check("t6_stall_cycle", 64'(stalled + 1), 64'd8);
      @(posedge clk);
      #1;
      m_cyc[1] = 1'b0;
      m_stb[1] = 1'b0;
      @(negedge clk);
      check("t6_err_one_cycle", m_err, '0);
      idle(5);
      @(negedge clk);
      check("t6_flag_sticky", timeout_flag, 1'b1);
      ack_mode = 1'b1;
      do_reset();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter_nx1.md
Name: wb_rr_arbiter_nx1

Overview:
Round-robin Wishbone arbiter that shares one slave port between N_MASTERS requesting masters. Used in front of a single shared target, such as a memory controller or peripheral bridge, or on a slave leg of the NxN interconnect. It holds the grant for the full duration of a master's CYC, so a burst or read-modify-write is never split. Uses flattened vector ports.

Parameters:
WB_ADDR_WIDTH, 32, address width
WB_DATA_WIDTH, 32, data width (multiple of 8)
N_MASTERS, 3, number of requesting masters (2..8)
TIMEOUT_CYCLES, 256, watchdog limit (used only when WB_ARB_TIMEOUT_EN is defined)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
m_adr  in  N_MASTERS*WB_ADDR_WIDTH  master addresses; master i occupies slice i
m_dat_w  in  N_MASTERS*WB_DATA_WIDTH  master write data
m_sel  in  N_MASTERS*(WB_DATA_WIDTH/8)  byte selects
m_cti  in  N_MASTERS*3  cycle type
m_bte  in  N_MASTERS*2  burst type
m_cyc, m_stb, m_we  in  N_MASTERS  per-master CYC/STB/WE
m_dat_r  out  WB_DATA_WIDTH  read data, broadcast to all masters
m_ack, m_err  out  N_MASTERS  per-master ACK/ERR
s_adr, s_dat_w, s_sel, s_cti, s_bte, s_cyc, s_stb, s_we  out  matching widths  slave request
s_dat_r  in  WB_DATA_WIDTH  slave read data
s_ack, s_err  in  1  slave response
gnt  out  N_MASTERS  one-hot current grant (debug/perf)

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rstn.
- Reset values: state IDLE, gnt=0, s_cyc=0, s_stb=0, s_we=0, other s_* = 0, m_ack=0, m_err=0, priority pointer last=N_MASTERS-1, so master 0 wins first.
- FSM IDLE:
  - When any m_cyc is high, select the first requester searching last+1, last+2, … with wrap-around modulo N_MASTERS.
  - Register gnt and last, then go to GRANT.
  - Arbitration latency: exactly 1 cycle from m_cyc rising to s_cyc rising.
- FSM GRANT:
  - s_* is a combinational mux of the granted master's slice.
  - s_cyc = m_cyc[g] and s_stb = m_stb[g] & m_cyc[g].
  - m_ack[g] = s_ack and m_err[g] = s_err. All non-granted m_ack/m_err are 0.
  - m_dat_r = s_dat_r.
- FSM GRANT -> RELEASE: when m_cyc[g]=0.
- FSM RELEASE: one dead cycle with gnt=0 and s_cyc=0, then IDLE. This guarantees slave CYC deasserts between owners.
- Non-granted masters simply wait; no response is produced for them.
- Simultaneous requests: round-robin order decides. After master k is served, master k+1 has highest priority.
- A master dropping CYC in the same cycle it is granted: the grant is still taken; next cycle goes to RELEASE. No slave strobe is issued since s_stb is gated by m_cyc.
- s_ack and s_err asserted together: both are forwarded. s_ack/s_err outside GRANT are ignored.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous). The pointer resets.
- When not in GRANT, s_* are driven 0.

Optional Feature:
WB_ARB_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on grant and on any s_ack/s_err.
  - It increments each GRANT cycle with s_stb=1.
  - On reaching TIMEOUT_CYCLES, drive m_err[g]=1 for one cycle, force s_cyc=s_stb=0, and go to RELEASE. Masters must drop CYC after ERR.
  - A sticky output timeout_flag (1 bit, reset 0) is added to the port list.
- Undefined: no counter and no timeout_flag port; the grant holds indefinitely.

Decomposition:
- Package wb_arb_pkg:
  - state enum {IDLE, GRANT, RELEASE}
  - function rr_pick(req, last) returning an index
  - NO_MASTER constant (all ones)
- One sub-module: wb_rr_prio_enc (parameterised N) computes the next grant index from req and last. It is reusable by the NxN interconnect.

Test Plan:
1. Reset, then master 1 only asserts cyc/stb, write adr 0x100 dat 0xDEADBEEF -> s_cyc rises 1 cycle later, s_adr=0x100; ack returns on m_ack[1] only; gnt=3'b010.
2. Masters 0, 1, 2 request simultaneously, each 1 transfer -> service order 0,1,2. Then a second simultaneous round -> order 0,1,2 again (pointer wrapped at 2).
3. Master 0 holds cyc for a 4-beat burst (cti=3'b010) while master 2 requests -> master 2 granted only after m_cyc[0] falls plus one RELEASE cycle with s_cyc=0.
4. Slave returns s_err on master 2's read -> m_err[2]=1, m_ack all 0, m_err[0..1]=0.
5. Assert rstn=0 mid-burst -> s_cyc, gnt, m_ack drop in the same cycle without a clock edge. After release, master 0 is served first.
6. WB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, slave never acks -> m_err[g] pulses on the 8th stalled cycle, s_cyc drops, timeout_flag=1 until reset.
